// File: rtl/lif_pkg.sv
// Shared types and helpers for the time-multiplexed LIF neuron array.
package lif_pkg;

  localparam int STATE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_DONE   = 2'd2
  } fsm_state_t;

  // Clamp a one-bit-wider sum back into the 8-bit range.
  function automatic logic [STATE_W-1:0] sat255(input logic [STATE_W:0] x);
    return x[STATE_W] ? {STATE_W{1'b1}} : x[STATE_W-1:0];
  endfunction

endpackage

// File: rtl/lif_update_core.sv
// Combinational single-neuron LIF step with adaptive threshold.
module lif_update_core
  import lif_pkg::*;
#(
  parameter int THRESHOLD_INC = 2,
  parameter int THRESHOLD_DEC = 1,
  parameter int THRESHOLD_MIN = 16
) (
  input  logic [STATE_W-1:0] i_s,
  input  logic [STATE_W-1:0] i_t,
  input  logic [STATE_W-1:0] i_c,
  output logic [STATE_W-1:0] o_s_next,
  output logic [STATE_W-1:0] o_t_next,
  output logic               o_spike
);

  logic [STATE_W-1:0] w_t_inc;
  logic [STATE_W-1:0] w_s_charge;
  logic [STATE_W-1:0] w_s_leak;

  assign o_spike    = (i_s >= i_t);
  assign w_t_inc    = sat255({1'b0, i_t} + (STATE_W+1)'(THRESHOLD_INC));
  assign w_s_charge = sat255({1'b0, i_c} + {2'b00, i_s[STATE_W-1:1]});
  assign w_s_leak   = i_s - {3'b000, i_s[STATE_W-1:3]};

  always_comb begin
    o_s_next = i_s;
    o_t_next = i_t;
    if (o_spike) begin
      o_s_next = '0;
      o_t_next = w_t_inc;
    end else begin
      o_s_next = (i_c != '0) ? w_s_charge : w_s_leak;
      // Threshold only decays while it sits above the floor.
      if (i_t > STATE_W'(THRESHOLD_MIN)) o_t_next = i_t - STATE_W'(THRESHOLD_DEC);
    end
  end

endmodule

// File: rtl/lif_array_scheduler.sv
// Sweeps N_NEURONS virtual LIF neurons through one shared update core per tick,
// queueing spiking addresses into a small AER FIFO.
//   state     | meaning
//   ST_IDLE   | waiting for tick_i
//   ST_UPDATE | updating neuron r_idx, stalls while a spike cannot be queued
//   ST_DONE   | one-cycle done_o pulse, then back to idle
module lif_array_scheduler
  import lif_pkg::*;
#(
  parameter int N_NEURONS     = 8,
  parameter int ADDR_W        = 3,
  parameter int THRESHOLD     = 32,
  parameter int THRESHOLD_INC = 2,
  parameter int THRESHOLD_DEC = 1,
  parameter int THRESHOLD_MIN = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              tick_i,
  input  logic              cur_valid_i,
  output logic              cur_ready_o,
  input  logic [ADDR_W-1:0] cur_addr_i,
  input  logic [7:0]        cur_i,
  output logic              spk_valid_o,
  input  logic              spk_ready_i,
  output logic [ADDR_W-1:0] spk_addr_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              overrun_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_NEURONS - 1);

  logic [STATE_W-1:0] r_state  [N_NEURONS];
  logic [STATE_W-1:0] r_thr    [N_NEURONS];
  logic [STATE_W-1:0] r_curbuf [N_NEURONS];

  fsm_state_t        r_fsm, w_fsm_next;
  logic [ADDR_W-1:0] r_idx, w_idx_next;

  logic [ADDR_W-1:0] r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_cnt;

  logic r_cur_ready;
  logic r_overrun;

  logic [STATE_W-1:0] w_s_next, w_t_next;
  logic               w_spike;
  logic               w_wr, w_pop, w_full, w_in_update, w_stall, w_commit, w_push;

  lif_update_core #(
    .THRESHOLD_INC(THRESHOLD_INC),
    .THRESHOLD_DEC(THRESHOLD_DEC),
    .THRESHOLD_MIN(THRESHOLD_MIN)
  ) u_core (
    .i_s      (r_state[r_idx]),
    .i_t      (r_thr[r_idx]),
    .i_c      (r_curbuf[r_idx]),
    .o_s_next (w_s_next),
    .o_t_next (w_t_next),
    .o_spike  (w_spike)
  );

  assign w_wr        = cur_valid_i & r_cur_ready;
  assign w_pop       = (r_cnt != '0) & spk_ready_i;
  assign w_full      = (r_cnt == CNT_W'(FIFO_DEPTH));
  assign w_in_update = (r_fsm == ST_UPDATE);
  // A pop in the same cycle frees the slot the spike needs.
  assign w_stall     = w_in_update & w_spike & w_full & ~w_pop;
  assign w_commit    = w_in_update & ~w_stall;
  assign w_push      = w_commit & w_spike;

  always_comb begin
    w_fsm_next = r_fsm;
    w_idx_next = r_idx;
    case (r_fsm)
      ST_IDLE: begin
        if (tick_i) begin
          w_fsm_next = ST_UPDATE;
          w_idx_next = '0;
        end
      end
      ST_UPDATE: begin
        if (w_commit) begin
          if (r_idx == LAST_IDX) w_fsm_next = ST_DONE;
          else                   w_idx_next = r_idx + 1'b1;
        end
      end
      ST_DONE: w_fsm_next = ST_IDLE;
      default: w_fsm_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fsm       <= ST_IDLE;
      r_idx       <= '0;
      r_cur_ready <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_fsm       <= w_fsm_next;
      r_idx       <= w_idx_next;
      r_cur_ready <= 1'b1;
      if (tick_i && (r_fsm != ST_IDLE)) r_overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        r_state[i]  <= '0;
        r_thr[i]    <= STATE_W'(THRESHOLD);
        r_curbuf[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_NEURONS; i++) begin
        if (w_commit && (r_idx == ADDR_W'(i))) begin
          r_state[i]  <= w_s_next;
          r_thr[i]    <= w_t_next;
          // A write landing on the neuron being committed starts the next accumulation.
          r_curbuf[i] <= (w_wr && (cur_addr_i == ADDR_W'(i))) ? cur_i : '0;
        end else if (w_wr && (cur_addr_i == ADDR_W'(i))) begin
          r_curbuf[i] <= sat255({1'b0, r_curbuf[i]} + {1'b0, cur_i});
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= r_idx;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign cur_ready_o = r_cur_ready;
  assign spk_valid_o = (r_cnt != '0);
  assign spk_addr_o  = r_fifo[r_rd_ptr];
  assign busy_o      = (r_fsm != ST_IDLE);
  assign done_o      = (r_fsm == ST_DONE);
  assign overrun_o   = r_overrun;

endmodule
